// File: rtl/coinc_window_checker.sv
// rtl/coinc_window_checker.sv - N-channel coincidence checker with bounded window
// Optional window timeout compiled in with `define COINC_TIMEOUT_EN.
module coinc_window_checker #(
  parameter int NUM_CH = 4,
  parameter int WIN_W  = 8,
  parameter int MULT_W = $clog2(NUM_CH + 1)
) (
  input  logic              entry_clock,
  input  logic              reset,
  input  logic              req_coinc,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [WIN_W-1:0]  window_len,
  input  logic [MULT_W-1:0] min_mult,
  output logic              coinc_met,
  output logic              coinc_timeout,
  output logic [NUM_CH-1:0] hit_map,
  output logic [MULT_W-1:0] hit_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    TBD  = 2'b01,
    DONE = 2'b10,
    FAIL = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [MULT_W-1:0] mult_q, mult_d;
  logic              met_d, timeout_d;
  logic [NUM_CH-1:0] map_d, nxt_map;
  logic [MULT_W-1:0] count_d, nxt_cnt;
  logic              go_idle;

`ifdef COINC_TIMEOUT_EN
  logic [WIN_W-1:0]  win_q, win_d;
`else
  logic              unused_window_len;
  assign unused_window_len = ^window_len;
`endif

  always_comb begin
    nxt_map = hit_map | (ch_valid & ch_mask);
    nxt_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      nxt_cnt = nxt_cnt + MULT_W'(nxt_map[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    mult_d    = mult_q;
    met_d     = coinc_met;
    timeout_d = coinc_timeout;
    map_d     = hit_map;
    count_d   = hit_count;
    go_idle   = 1'b0;
`ifdef COINC_TIMEOUT_EN
    win_d     = win_q;
`endif
    case (state_q)
      IDLE: begin
        go_idle = 1'b1;
        if (req_coinc) begin
          state_d = TBD;
          mult_d  = min_mult;
`ifdef COINC_TIMEOUT_EN
          win_d   = window_len;
`endif
        end
      end
      TBD: begin
        if (!req_coinc) begin
          go_idle = 1'b1;
        end else begin
          map_d   = nxt_map;
          count_d = nxt_cnt;
          // Multiplicity is tested before expiry so met wins on the last window edge.
          if (nxt_cnt >= mult_q) begin
            state_d = DONE;
            met_d   = 1'b1;
          end
`ifdef COINC_TIMEOUT_EN
          else if (win_q == '0) begin
            state_d   = FAIL;
            timeout_d = 1'b1;
          end else begin
            win_d = win_q - 1'b1;
          end
`endif
        end
      end
      DONE, FAIL: begin
        if (!req_coinc) go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      if (state_q != IDLE || !req_coinc) state_d = IDLE;
      met_d     = 1'b0;
      timeout_d = 1'b0;
      map_d     = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge entry_clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mult_q        <= '0;
      coinc_met     <= 1'b0;
      coinc_timeout <= 1'b0;
      hit_map       <= '0;
      hit_count     <= '0;
    end else begin
      state_q       <= state_d;
      mult_q        <= mult_d;
      coinc_met     <= met_d;
      coinc_timeout <= timeout_d;
      hit_map       <= map_d;
      hit_count     <= count_d;
    end
  end

`ifdef COINC_TIMEOUT_EN
  always_ff @(posedge entry_clock or posedge reset) begin
    if (reset) win_q <= '0;
    else       win_q <= win_d;
  end
`endif

endmodule

// File: tb/tb_coinc_window_checker.sv
// tb/tb_coinc_window_checker.sv - randomized bench against a behavioural coincidence model
// Expected timeout behaviour follows `define COINC_TIMEOUT_EN.
module tb_coinc_window_checker;

  logic       entry_clock = 1'b0;
  logic       reset;
  logic       req_coinc;
  logic [3:0] ch_valid;
  logic [3:0] ch_mask;
  logic [7:0] window_len;
  logic [2:0] min_mult;
  logic       coinc_met;
  logic       coinc_timeout;
  logic [3:0] hit_map;
  logic [2:0] hit_count;

`ifdef COINC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  coinc_window_checker dut (
    .entry_clock   (entry_clock),
    .reset         (reset),
    .req_coinc     (req_coinc),
    .ch_valid      (ch_valid),
    .ch_mask       (ch_mask),
    .window_len    (window_len),
    .min_mult      (min_mult),
    .coinc_met     (coinc_met),
    .coinc_timeout (coinc_timeout),
    .hit_map       (hit_map),
    .hit_count     (hit_count)
  );

  always #5 entry_clock = ~entry_clock;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 = not checking, 1 = window open, 2 = verdict reached.
  int         phase;
  int         elapsed;
  int         m_wl;
  int         m_mm;
  logic [3:0] m_map;
  bit         m_met;
  bit         m_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = 0; elapsed = 0; m_map = '0; m_met = 0; m_to = 0; m_wl = 0; m_mm = 0;
  endtask

  task automatic model_edge();
    if (phase == 0) begin
      m_map = '0; m_met = 0; m_to = 0;
      if (req_coinc) begin
        phase = 1; elapsed = 0; m_wl = int'(window_len); m_mm = int'(min_mult);
      end
    end else if (!req_coinc) begin
      phase = 0; m_map = '0; m_met = 0; m_to = 0;
    end else if (phase == 1) begin
      elapsed++;
      m_map = m_map | (ch_valid & ch_mask);
      if ($countones(m_map) >= m_mm) begin
        m_met = 1; phase = 2;
      end else if (TO_EN && elapsed == m_wl + 1) begin
        m_to = 1; phase = 2;
      end
    end
  endtask

  task automatic step();
    @(posedge entry_clock);
    model_edge();
    #1;
    check("hit_map", 32'(hit_map), 32'(m_map));
    check("hit_count", 32'(hit_count), 32'($countones(m_map)));
    check("coinc_met", 32'(coinc_met), 32'(m_met));
    check("coinc_timeout", 32'(coinc_timeout), 32'(m_to));
  endtask

  task automatic start(input logic [3:0] mask, input int mm, input int wl);
    ch_mask = mask; min_mult = 3'(mm); window_len = 8'(wl); req_coinc = 1'b1;
  endtask

  task automatic release_req();
    req_coinc = 1'b0; ch_valid = '0;
    step();
    check("release_clear", {28'(0), coinc_met, coinc_timeout, |hit_map, |hit_count}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_coinc = 0; ch_valid = 0; ch_mask = 0; window_len = 0; min_mult = 0;
    model_reset();
    #2;
    check("reset_outputs", {28'(0), coinc_met, coinc_timeout, |hit_map, |hit_count}, 32'd0);
    #10 reset = 1'b0;

    // Basic multiplicity: ch0 on TBD edge 2, ch2 on TBD edge 5.
    start(4'b1111, 2, 10);
    step();
    step();
    ch_valid = 4'b0001; step();
    check("basic_map1", 32'(hit_map), 32'h1);
    ch_valid = 4'b0000; step(); step();
    ch_valid = 4'b0100; step();
    check("basic_map2", 32'(hit_map), 32'h5);
    check("basic_met", 32'(coinc_met), 32'd1);
    check("basic_count", 32'(hit_count), 32'd2);
    ch_valid = 4'b1010; step();
    check("sticky_map", 32'(hit_map), 32'h5);
    release_req();

    // Timeout with masking: ch0 and ch3 toggle, only ch0 counts.
    start(4'b0011, 2, 3);
    step();
    for (int i = 0; i < 4; i++) begin
      ch_valid = (i % 2 == 0) ? 4'b1001 : 4'b1000;
      step();
    end
    check("mask_map", 32'(hit_map), 32'h1);
    check("mask_timeout", 32'(coinc_timeout), 32'(TO_EN));
    check("mask_no_met", 32'(coinc_met), 32'd0);
    release_req();

    // Same-edge race: zero-length window satisfied on its only edge.
    start(4'b1111, 1, 0);
    ch_valid = 4'b0010;
    step();
    step();
    check("race_met", 32'(coinc_met), 32'd1);
    check("race_timeout", 32'(coinc_timeout), 32'd0);
    release_req();

    // min_mult = 0 meets on first TBD edge with no valid channels.
    start(4'b0000, 0, 7);
    step(); step();
    check("mm0_met", 32'(coinc_met), 32'd1);
    release_req();

    // Unreachable multiplicity.
    start(4'b0011, 3, 2);
    ch_valid = 4'b1111;
    step();
    for (int i = 0; i < 3; i++) step();
    check("mm3_timeout", 32'(coinc_timeout), 32'(TO_EN));
    check("mm3_no_met", 32'(coinc_met), 32'd0);
    release_req();

    // Asynchronous reset mid-window.
    start(4'b1111, 4, 20);
    ch_valid = 4'b0001;
    step(); step(); step();
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("async_reset", {28'(0), coinc_met, coinc_timeout, |hit_map, |hit_count}, 32'd0);
    #1 reset = 1'b0;
    ch_valid = '0;
    step();

    // Random traffic with occasional request drops.
    for (int n = 0; n < 3000; n++) begin
      req_coinc  = ($urandom_range(0, 15) != 0);
      ch_valid   = 4'($urandom() & $urandom());
      if ($urandom_range(0, 7) == 0) ch_mask = 4'($urandom());
      window_len = 8'($urandom_range(0, 12));
      min_mult   = 3'($urandom_range(0, 4));
      step();
      if (coinc_met && coinc_timeout) check("met_and_timeout", 32'd1, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coinc_window_checker.md
# coinc_window_checker

Multi-channel, parametrised coincidence checker for the entry path. It opens a coincidence window when `req_coinc` is asserted. During the window it accumulates which unmasked channels have presented a valid sequence. It declares coincidence once the number of distinct hit channels reaches a programmable multiplicity, or declares a timeout when the window length expires first. It sits between the per-channel sequence validators and the entry acceptance logic, and it generalises the single-partner, unbounded-wait coincidence check to N channels with a bounded window.

## Interface
Parameters:
- `NUM_CH`, default 4: number of partner channels monitored (≥1).
- `WIN_W`, default 8: width of the window length and window counter.
- `MULT_W`, default `$clog2(NUM_CH+1)`: width of the multiplicity fields.

Ports:
- `entry_clock`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_coinc`  in  1  high requests a coincidence check; low returns the block to IDLE.
- `ch_valid`  in  NUM_CH  per-channel "currently has a valid sequence".
- `ch_mask`  in  NUM_CH  1 means the channel participates; masked bits are ignored.
- `window_len`  in  WIN_W  window length in cycles; sampled on IDLE→TBD.
- `min_mult`  in  MULT_W  required number of distinct hit channels; sampled on IDLE→TBD.
- `coinc_met`  out  1  registered; coincidence achieved (sticky while `req_coinc` stays high).
- `coinc_timeout`  out  1  registered; window expired without coincidence (sticky while `req_coinc` stays high).
- `hit_map`  out  NUM_CH  registered; accumulated unmasked channels seen valid in the current check.
- `hit_count`  out  MULT_W  registered; popcount of `hit_map`.

## Operation
- Registered 2-bit state machine with sequential encoding: IDLE=00, TBD=01, DONE=10, FAIL=11.
- **Reset:** state=IDLE; `coinc_met`=0, `coinc_timeout`=0, `hit_map`=0, `hit_count`=0; window counter=0; latched `min_mult`=0.
- **IDLE:** all outputs are driven to 0 each edge. If `req_coinc`=1, the block moves to TBD, loads the counter with `window_len`, and latches `min_mult`.
- **TBD:** each edge computes `nxt_map = hit_map | (ch_valid & ch_mask)` and `nxt_cnt = popcount(nxt_map)`, then registers both. Priority at that edge:
  - `req_coinc`=0 → IDLE, with the same clears as IDLE.
  - Else `nxt_cnt` ≥ latched `min_mult` → DONE, `coinc_met`←1.
  - Else counter==0 → FAIL, `coinc_timeout`←1 (only with the macro defined; see Configuration).
  - Else counter←counter−1 and the block stays in TBD.
- **DONE:** `coinc_met`=1. `hit_map` and `hit_count` are frozen. The block holds until `req_coinc`=0, then goes to IDLE.
- **FAIL:** `coinc_timeout`=1. `hit_map` and `hit_count` are frozen. The block holds until `req_coinc`=0, then goes to IDLE.
- `coinc_met` and `coinc_timeout` are never both 1.
- **Illegal state:** there is no unreachable encoding. Any X recovery returns the block to IDLE with outputs cleared.
- **Boundaries:**
  - Latched `min_mult`=0: coinc is met on the first TBD edge regardless of inputs.
  - `min_mult` > popcount(`ch_mask`): coinc can never be met, so the block times out (or waits forever without the macro).
  - `ch_mask` and `ch_valid` are live every TBD cycle. Only `window_len` and `min_mult` are sampled.
  - A channel counts once, however long or often it is valid.
  - Reset asserted mid-TBD returns the block to IDLE immediately, asynchronously.

## Timing
- IDLE→TBD takes 1 edge after `req_coinc` is sampled high. Channels are first sampled on the following edge.
- With `window_len`=N, TBD samples the channels on N+1 edges. Timeout is registered on the (N+1)th TBD edge.
- `coinc_met` rises on the same edge that the qualifying `ch_valid` is sampled. Latency is 1 cycle from the input change.
- If the final window edge also satisfies the multiplicity, met wins over timeout.
- The DONE/FAIL→IDLE transition and the output clear happen on the first edge with `req_coinc`=0.

## Configuration
- `COINC_TIMEOUT_EN`
  - **Defined:** the window counter and the FAIL state are compiled in, and behaviour is as above.
  - **Undefined:** the counter is removed and TBD never times out (unbounded wait). `coinc_timeout` is tied to 0, `window_len` is ignored, and FAIL is unreachable.

## Test plan
- **Basic multiplicity.** Setup: NUM_CH=4, mask=4'b1111, min_mult=2, window_len=10; `req_coinc`=1, then ch0 valid on TBD edge 2 and ch2 valid on TBD edge 5. Required: `hit_map` is 4'b0001, then 4'b0101; `coinc_met`=1 on edge 5; `hit_count`=2.
- **Timeout with masking.**
  - Setup: mask=4'b0011, min_mult=2, window_len=3; only ch0 and ch3 toggle.
  - Required: `hit_map`=4'b0001; `coinc_timeout`=1 on the 4th TBD edge; `coinc_met` stays 0.
  - Without the macro: the block stays in TBD indefinitely.
- **Same-edge race.** Setup: window_len=0, min_mult=1, ch1 valid on the first TBD edge. Required: `coinc_met`=1 and `coinc_timeout`=0.
- **Sticky then release.**
  - From DONE, toggle `ch_valid`. Required: outputs frozen.
  - Drop `req_coinc`. Required: all outputs 0 next edge.
  - Re-raise `req_coinc` with a new window_len=5. Required: a fresh check with the new length.
- **Degenerate thresholds.**
  - min_mult=0. Required: `coinc_met`=1 on the first TBD edge.
  - min_mult=3 with mask=4'b0011. Required: timeout after window_len+1 TBD edges.
- **Asynchronous reset.** Setup: assert reset mid-TBD, between clock edges. Required: `coinc_met`, `coinc_timeout`, `hit_map` and `hit_count` go to 0 immediately, and the block returns to IDLE.
